// File: rtl/dram_pkg.sv
// Shared types and defaults for the FastRAM DRAM sequencer and its refresh timer.
package dram_pkg;

  localparam int REFRESH_INTERVAL_DEF = 110;  // 15.6 us at 7.09 MHz
  localparam int MAX_OWED_DEF         = 8;
  localparam int REF_RAS_CYCLES_DEF   = 2;

  localparam int OWED_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC_RAS = 3'd1,
    ACC_CAS = 3'd2,
    ACC_PRE = 3'd3,
    REF_CAS = 3'd4,
    REF_RAS = 3'd5,
    REF_PRE = 3'd6
  } state_t;

endpackage

// File: rtl/dram_refresh_scheduler_if.sv
// Bus-side request/strobe bundle between the decode logic, the sequencer and the DRAM.
interface dram_refresh_scheduler_if;
  import dram_pkg::*;

  logic              REQ;
  logic              UDSn;
  logic              LDSn;
  logic              RWn;
  logic              RASn;
  logic              UCASn;
  logic              LCASn;
  logic              COLSEL;
  logic              MEMWn;
  logic              BUSY;
  logic [OWED_W-1:0] REF_OWED;
  logic              REF_OVERRUN;

  modport master (
    output REQ, UDSn, LDSn, RWn,
    input  RASn, UCASn, LCASn, COLSEL, MEMWn, BUSY, REF_OWED, REF_OVERRUN
  );

  modport slave (
    input  REQ, UDSn, LDSn, RWn,
    output RASn, UCASn, LCASn, COLSEL, MEMWn, BUSY, REF_OWED, REF_OVERRUN
  );

endinterface

// File: rtl/refresh_timer.sv
// Refresh interval counter plus the owed-refresh bookkeeping and sticky overrun flag.
module refresh_timer
  import dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_OWED         = MAX_OWED_DEF
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              consume,
  output logic [OWED_W-1:0] owed,
  output logic              saturated,
  output logic              overrun
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(MAX_OWED);

  logic [CNT_W-1:0] interval_cnt;
  logic             tick;
  logic             dec;

  assign tick      = (interval_cnt == '0);
  assign saturated = (owed == OWED_MAX);
  assign dec       = consume && (owed != '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      interval_cnt <= RELOAD;
    end else if (tick) begin
      interval_cnt <= RELOAD;
    end else begin
      interval_cnt <= interval_cnt - 1'b1;
    end
  end

  // A tick and a consume in the same cycle cancel; a tick at the ceiling is lost and flagged.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      owed    <= '0;
      overrun <= 1'b0;
    end else begin
      if (tick && !dec && !saturated) begin
        owed <= owed + 1'b1;
      end else if (!tick && dec) begin
        owed <= owed - 1'b1;
      end
      if (tick && saturated) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_refresh_scheduler.sv
// FastRAM DRAM sequencer: arbitrates CPU accesses against CAS-before-RAS refresh
// and drives registered strobes, row/column select and write enable.
module dram_refresh_scheduler
  import dram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_OWED         = MAX_OWED_DEF,
  parameter int REF_RAS_CYCLES   = REF_RAS_CYCLES_DEF
) (
  input logic                     CLK,
  input logic                     RESETn,
  dram_refresh_scheduler_if.slave bus
);

  localparam int RC_W = (REF_RAS_CYCLES > 1) ? $clog2(REF_RAS_CYCLES) : 1;
  localparam logic [RC_W-1:0] RAS_LOAD = RC_W'(REF_RAS_CYCLES - 1);

  state_t            state;
  logic [RC_W-1:0]   ras_cnt;
  logic              consume;
  logic [OWED_W-1:0] owed;
  logic              saturated;
  logic              overrun;

  // Owed count drops on the same edge that enters REF_PRE.
  assign consume = (state == REF_RAS) && (ras_cnt == '0);

  refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_OWED         (MAX_OWED)
  ) u_refresh_timer (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .consume   (consume),
    .owed      (owed),
    .saturated (saturated),
    .overrun   (overrun)
  );

  assign bus.REF_OWED    = owed;
  assign bus.REF_OVERRUN = overrun;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= IDLE;
      ras_cnt    <= '0;
      bus.RASn   <= 1'b1;
      bus.UCASn  <= 1'b1;
      bus.LCASn  <= 1'b1;
      bus.MEMWn  <= 1'b1;
      bus.COLSEL <= 1'b0;
      bus.BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A saturated owed count pre-empts the CPU; otherwise the CPU goes first.
          if (saturated || (!bus.REQ && owed != '0)) begin
            state     <= REF_CAS;
            bus.UCASn <= 1'b0;
            bus.LCASn <= 1'b0;
            bus.RASn  <= 1'b1;
            bus.BUSY  <= 1'b1;
          end else if (bus.REQ) begin
            state      <= ACC_RAS;
            bus.RASn   <= 1'b0;
            bus.COLSEL <= 1'b0;
            bus.BUSY   <= 1'b1;
          end
        end

        ACC_RAS: begin
          state      <= ACC_CAS;
          bus.COLSEL <= 1'b1;
        end

        ACC_CAS: begin
          if (!bus.REQ) begin
            state      <= ACC_PRE;
            bus.RASn   <= 1'b1;
            bus.UCASn  <= 1'b1;
            bus.LCASn  <= 1'b1;
            bus.MEMWn  <= 1'b1;
            bus.COLSEL <= 1'b0;
          end else begin
            // Late data strobes on writes: a CAS that has dropped stays low.
            if (!bus.UDSn) bus.UCASn <= 1'b0;
            if (!bus.LDSn) bus.LCASn <= 1'b0;
            bus.MEMWn <= bus.RWn | (bus.UDSn & bus.LDSn);
          end
        end

        ACC_PRE: begin
          state    <= IDLE;
          bus.BUSY <= 1'b0;
        end

        REF_CAS: begin
          state    <= REF_RAS;
          bus.RASn <= 1'b0;
          ras_cnt  <= RAS_LOAD;
        end

        REF_RAS: begin
          if (ras_cnt == '0) begin
            state     <= REF_PRE;
            bus.RASn  <= 1'b1;
            bus.UCASn <= 1'b1;
            bus.LCASn <= 1'b1;
          end else begin
            ras_cnt <= ras_cnt - 1'b1;
          end
        end

        REF_PRE: begin
          state    <= IDLE;
          bus.BUSY <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          bus.RASn   <= 1'b1;
          bus.UCASn  <= 1'b1;
          bus.LCASn  <= 1'b1;
          bus.MEMWn  <= 1'b1;
          bus.COLSEL <= 1'b0;
          bus.BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_refresh_scheduler.md
# dram_refresh_scheduler

Sequences the on-board FastRAM DRAM array and arbitrates between CPU accesses and periodic CAS-before-RAS refresh. It sits between the address-decode/autoconfig logic, which supplies a qualified RAM request, and the DRAM strobes and row/column mux select. Refresh is normally hidden in bus idle time. Refreshes are owed and tracked, so a long CPU burst never drops a refresh silently.

## Interface
Parameters:
- REFRESH_INTERVAL, 110, CLK cycles between refresh ticks (15.6 µs at 7.09 MHz).
- MAX_OWED, 8, saturating limit of owed refreshes; reaching it forces refresh ahead of CPU access.
- REF_RAS_CYCLES, 2, cycles RASn is held low during refresh (≥1).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RESETn  in  1  asynchronous, active-low reset.
- REQ  in  1  qualified RAM cycle: address matched, ASn low, board configured; held until bus cycle ends.
- UDSn  in  1  upper data strobe.
- LDSn  in  1  lower data strobe.
- RWn  in  1  bus read/write.
- RASn  out  1  DRAM row strobe.
- UCASn  out  1  upper-byte column strobe.
- LCASn  out  1  lower-byte column strobe.
- COLSEL  out  1  1 = column address on MADDR, 0 = row address.
- MEMWn  out  1  DRAM write enable.
- BUSY  out  1  high in any non-IDLE state.
- REF_OWED  out  4  current owed-refresh count.
- REF_OVERRUN  out  1  sticky; set when a tick arrives with REF_OWED == MAX_OWED.

## Operation
- All outputs are registered. Reset values:
  - RASn, UCASn, LCASn and MEMWn are 1.
  - COLSEL, BUSY, REF_OWED and REF_OVERRUN are 0.
  - State is IDLE.
  - Interval counter is REFRESH_INTERVAL-1.
- Interval counter:
  - Decrements every cycle.
  - At 0 it reloads and issues a tick.
  - A tick increments REF_OWED, saturating at MAX_OWED.
  - A tick at saturation sets REF_OVERRUN, which clears only on reset.
- Owed counter:
  - Decrements on entry to REF_PRE.
  - A tick and a decrement in the same cycle leave REF_OWED unchanged.
- States: IDLE, ACC_RAS, ACC_CAS, ACC_PRE, REF_CAS, REF_RAS, REF_PRE.
- IDLE priority:
  1. REF_OWED == MAX_OWED → REF_CAS.
  2. REQ → ACC_RAS.
  3. REF_OWED > 0 → REF_CAS.
  4. Otherwise stay in IDLE.
- ACC_RAS (one cycle): RASn 0, COLSEL 0, then → ACC_CAS.
- ACC_CAS:
  - COLSEL 1, RASn 0.
  - Each cycle, UCASn latches 0 if UDSn is sampled 0, and LCASn latches 0 if LDSn is sampled 0. Once low, a CAS stays low (sticky) until exit.
  - MEMWn = RWn | (UDSn & LDSn), registered.
  - REQ low → ACC_PRE.
- ACC_PRE (one cycle):
  - All strobes 1, MEMWn 1, COLSEL 0.
  - Then → IDLE. Back-to-back REQ is accepted only from IDLE.
- REF_CAS (one cycle): UCASn and LCASn 0, RASn 1, then → REF_RAS.
- REF_RAS: RASn 0, both CAS 0, held REF_RAS_CYCLES cycles, then → REF_PRE.
- REF_PRE (one cycle): all strobes 1, then → IDLE.
- REQ arriving during refresh waits; refresh is never aborted.
- MEMWn is 1 in every refresh state and in IDLE.
- Reset mid-operation: strobes go inactive asynchronously and the state is lost. The owed count restarts at 0, and the interval counter restarts at REFRESH_INTERVAL-1.

## Timing
- REQ sampled high in IDLE at edge n:
  - RASn goes low after edge n.
  - COLSEL goes high after edge n+1.
  - CAS goes low after the first edge ≥ n+2 at which the strobe is sampled low.
- REQ sampled low in ACC_CAS at edge m: strobes go high after edge m; IDLE is reached after edge m+1.
- Worst-case REQ-to-RASn latency is 3+REF_RAS_CYCLES cycles (refresh just begun), or 1 cycle when idle.
- A refresh sequence is 2+REF_RAS_CYCLES cycles. CAS leads RAS by exactly 1 cycle.
- RASn is never low while COLSEL changes within an access, except at the ACC_RAS→ACC_CAS edge, which is the intended row-to-column switch.

## Structure
- Shared package dram_pkg holds:
  - the state enum (3-bit encoding);
  - defaults for REFRESH_INTERVAL, MAX_OWED and REF_RAS_CYCLES;
  - the REF_OWED width constant.
- Sub-module refresh_timer holds the interval counter, owed counter and overrun flag. Its interface is tick-in-consume/REF_OWED/saturated-out.
- The FSM and strobe registers stay in the top module.

## Test plan
- Reset release, REQ=0 for 110 cycles:
  - At cycle 110 REF_OWED becomes 1.
  - Next cycle REF_CAS runs with CAS low and RASn 1.
  - Then RASn is low for 2 cycles, then precharge.
  - REF_OWED returns to 0.
- Read access, REQ high for 6 cycles with UDSn=LDSn=0:
  - RASn low at +1, COLSEL at +2, both CAS low at +3.
  - All strobes high the cycle after REQ drops.
  - MEMWn stays 1 throughout.
- Byte write, RWn=0, only LDSn low, asserted 2 cycles after REQ:
  - Only LCASn goes low.
  - MEMWn goes 0.
  - UCASn stays 1.
- REQ held continuously for 9×110 cycles:
  - REF_OWED saturates at 8 and REF_OVERRUN sets.
  - After REQ drops, 8 back-to-back refreshes drain REF_OWED to 0.
- Interval tick coincident with REF_PRE entry: REF_OWED is unchanged.
- RESETn asserted while in REF_RAS:
  - RASn, UCASn and LCASn go 1 without waiting for a clock.
  - REF_OWED and REF_OVERRUN read 0.
